pulse_decoder: RTL and testbench

Receive-side counterpart of the pulse sequencer. Samples the sequencer's `sync_on` and `pulse_on` lines, either looped back internally or from the board pins. Reconstructs each frame's timing parameters in clk_pll cycles: period, sync width, first-pulse width, second-pulse start/end, and extra-pulse count/width. Publishes them once per frame with a valid strobe, so LabView readback and self-test can confirm the programmed sequence.

---
 rtl/pulse_decoder.sv | 244 ++++++++++++++++++++++++
 tb/tb_pulse_decoder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_decoder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pulse_decoder : recovers sync/pulse frame timing in clk_pll cycles
// Revision      : 1.0
// ----------------------------------------------------------------------------
module pulse_decoder #(
  parameter logic [31:0] TIMEOUT = 32'd200_000_000
) (
  input  logic        clk_pll,
  input  logic        reset,
  input  logic        sync_on,
  input  logic        pulse_on,
  output logic [31:0] meas_period,
  output logic [31:0] meas_syncw,
  output logic [31:0] meas_p1width,
  output logic [31:0] meas_p2start,
  output logic [31:0] meas_p2end,
  output logic [7:0]  meas_extra_cnt,
  output logic [31:0] meas_extra_width,
  output logic        meas_valid,
  output logic        err_incomplete,
  output logic        err_timeout
);

  localparam logic [31:0] c_cnt_max   = 32'hFFFF_FFFF;
  localparam logic [7:0]  c_extra_max = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_P1   = 3'd1,
    S_GAP  = 3'd2,
    S_P2   = 3'd3,
    S_POST = 3'd4
  } state_t;

  // Bit 0 carries sync_on, bit 1 carries pulse_on through identical stages.
  logic [1:0] w_raw;
  logic [1:0] r_s1;
  logic [1:0] r_s2;
  logic [1:0] r_d;
  logic [1:0] r_rise;
  logic [1:0] r_fall;
  logic [1:0] r_arm_cnt;
  logic       w_armed;

  state_t     r_state;
  state_t     w_state_next;

  logic [31:0] r_cnt;
  logic [31:0] w_cnt_inc;
  logic        w_in_frame;
  logic        w_sync_rise;
  logic        w_sync_fall;
  logic        w_pulse_rise;
  logic        w_pulse_fall;
  logic        w_pulse_lvl;
  logic        w_publish;
  logic        w_timeout;

  logic [31:0] r_syncw;
  logic [31:0] r_p1width;
  logic [31:0] r_p2start;
  logic [31:0] r_p2end;
  logic [7:0]  r_extra_cnt;
  logic [31:0] r_extra_start;
  logic [31:0] r_extra_width;

  logic        r_stg_valid;
  logic        r_stg_incomplete;
  logic [31:0] r_stg_period;
  logic [31:0] r_stg_syncw;
  logic [31:0] r_stg_p1width;
  logic [31:0] r_stg_p2start;
  logic [31:0] r_stg_p2end;
  logic [7:0]  r_stg_extra_cnt;
  logic [31:0] r_stg_extra_width;

  assign w_raw   = {pulse_on, sync_on};
  assign w_armed = (r_arm_cnt == 2'd3);

  // Edges are suppressed until the whole chain holds post-reset samples, so a
  // line that is already high at reset release is not mistaken for a rise.
  always_ff @(posedge clk_pll) begin
    if (reset) begin
      r_s1      <= 2'b00;
      r_s2      <= 2'b00;
      r_d       <= 2'b00;
      r_rise    <= 2'b00;
      r_fall    <= 2'b00;
      r_arm_cnt <= 2'd0;
    end else begin
      r_s1   <= w_raw;
      r_s2   <= r_s1;
      r_d    <= r_s2;
      r_rise <= {2{w_armed}} & r_s2 & ~r_d;
      r_fall <= {2{w_armed}} & ~r_s2 & r_d;
      if (!w_armed) begin
        r_arm_cnt <= r_arm_cnt + 2'd1;
      end
    end
  end

  assign w_sync_rise  = r_rise[0];
  assign w_sync_fall  = r_fall[0];
  assign w_pulse_rise = r_rise[1];
  assign w_pulse_fall = r_fall[1];
  assign w_pulse_lvl  = r_d[1];

  assign w_cnt_inc  = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + 32'd1;
  assign w_in_frame = (r_state != S_IDLE);
  assign w_publish  = w_sync_rise & w_in_frame;
  assign w_timeout  = w_in_frame & ~w_sync_rise & (w_cnt_inc == TIMEOUT);

  always_ff @(posedge clk_pll) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_sync_rise) begin
      w_state_next = w_pulse_lvl ? S_P1 : S_GAP;
    end else if (w_timeout) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_P1:    if (w_pulse_fall) w_state_next = S_GAP;
        S_GAP:   if (w_pulse_rise) w_state_next = S_P2;
        S_P2:    if (w_pulse_fall) w_state_next = S_POST;
        default: w_state_next = r_state;
      endcase
    end
  end

  // Fields take w_cnt_inc so a level held k sampled cycles reads back as k.
  always_ff @(posedge clk_pll) begin
    if (reset) begin
      r_cnt         <= 32'd0;
      r_syncw       <= 32'd0;
      r_p1width     <= 32'd0;
      r_p2start     <= 32'd0;
      r_p2end       <= 32'd0;
      r_extra_cnt   <= 8'd0;
      r_extra_start <= 32'd0;
      r_extra_width <= 32'd0;
    end else if (w_sync_rise) begin
      r_cnt         <= 32'd0;
      r_syncw       <= 32'd0;
      r_p1width     <= 32'd0;
      r_p2start     <= 32'd0;
      r_p2end       <= 32'd0;
      r_extra_cnt   <= 8'd0;
      r_extra_start <= 32'd0;
      r_extra_width <= 32'd0;
    end else if (w_in_frame && !w_timeout) begin
      r_cnt <= w_cnt_inc;
      if (w_sync_fall) begin
        r_syncw <= w_cnt_inc;
      end
      case (r_state)
        S_P1: begin
          if (w_pulse_fall) r_p1width <= w_cnt_inc;
        end
        S_GAP: begin
          if (w_pulse_rise) r_p2start <= w_cnt_inc;
        end
        S_P2: begin
          if (w_pulse_fall) r_p2end <= w_cnt_inc;
        end
        S_POST: begin
          if (w_pulse_rise) begin
            if (r_extra_cnt != c_extra_max) r_extra_cnt <= r_extra_cnt + 8'd1;
            r_extra_start <= w_cnt_inc;
          end
          if (w_pulse_fall) r_extra_width <= w_cnt_inc - r_extra_start;
        end
        default: begin
        end
      endcase
    end else begin
      r_cnt <= 32'd0;
    end
  end

  // Publish is staged one cycle so outputs land four edges after the raw rise.
  always_ff @(posedge clk_pll) begin
    if (reset) begin
      r_stg_valid       <= 1'b0;
      r_stg_incomplete  <= 1'b0;
      r_stg_period      <= 32'd0;
      r_stg_syncw       <= 32'd0;
      r_stg_p1width     <= 32'd0;
      r_stg_p2start     <= 32'd0;
      r_stg_p2end       <= 32'd0;
      r_stg_extra_cnt   <= 8'd0;
      r_stg_extra_width <= 32'd0;
    end else begin
      r_stg_valid <= w_publish;
      if (w_publish) begin
        r_stg_incomplete  <= (r_state != S_POST);
        r_stg_period      <= w_cnt_inc;
        r_stg_syncw       <= r_syncw;
        r_stg_p1width     <= r_p1width;
        r_stg_p2start     <= r_p2start;
        r_stg_p2end       <= r_p2end;
        r_stg_extra_cnt   <= r_extra_cnt;
        r_stg_extra_width <= r_extra_width;
      end
    end
  end

  always_ff @(posedge clk_pll) begin
    if (reset) begin
      meas_valid       <= 1'b0;
      err_incomplete   <= 1'b0;
      err_timeout      <= 1'b0;
      meas_period      <= 32'd0;
      meas_syncw       <= 32'd0;
      meas_p1width     <= 32'd0;
      meas_p2start     <= 32'd0;
      meas_p2end       <= 32'd0;
      meas_extra_cnt   <= 8'd0;
      meas_extra_width <= 32'd0;
    end else begin
      meas_valid  <= r_stg_valid;
      err_timeout <= w_timeout;
      if (r_stg_valid) begin
        err_incomplete   <= r_stg_incomplete;
        meas_period      <= r_stg_period;
        meas_syncw       <= r_stg_syncw;
        meas_p1width     <= r_stg_p1width;
        meas_p2start     <= r_stg_p2start;
        meas_p2end       <= r_stg_p2end;
        meas_extra_cnt   <= r_stg_extra_cnt;
        meas_extra_width <= r_stg_extra_width;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pulse_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_pulse_decoder : directed frames checked against a sample-level frame model
// Revision         : 1.0
// ----------------------------------------------------------------------------
module tb_pulse_decoder;

  localparam int T_OUT = 5000;

  logic        clk_pll = 1'b0;
  logic        reset;
  logic        sync_on;
  logic        pulse_on;
  logic [31:0] meas_period;
  logic [31:0] meas_syncw;
  logic [31:0] meas_p1width;
  logic [31:0] meas_p2start;
  logic [31:0] meas_p2end;
  logic [7:0]  meas_extra_cnt;
  logic [31:0] meas_extra_width;
  logic        meas_valid;
  logic        err_incomplete;
  logic        err_timeout;

  pulse_decoder #(.TIMEOUT(32'd5000)) dut (
    .clk_pll          (clk_pll),
    .reset            (reset),
    .sync_on          (sync_on),
    .pulse_on         (pulse_on),
    .meas_period      (meas_period),
    .meas_syncw       (meas_syncw),
    .meas_p1width     (meas_p1width),
    .meas_p2start     (meas_p2start),
    .meas_p2end       (meas_p2end),
    .meas_extra_cnt   (meas_extra_cnt),
    .meas_extra_width (meas_extra_width),
    .meas_valid       (meas_valid),
    .err_incomplete   (err_incomplete),
    .err_timeout      (err_timeout)
  );

  always #5 clk_pll = ~clk_pll;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int          at;
    logic [31:0] per, sw, p1, p2s, p2e, xw;
    logic [7:0]  xc;
    logic        inc;
  } pub_t;

  // Model state: raw samples are interpreted as offsets from the frame's sync rise.
  int   edge_cnt    = 0;
  int   rst_edge    = -1;
  int   valid_cnt   = 0;
  int   last_to_edge = -1;
  int   rise_edge   = 0;
  bit   prev_v = 0, prev_s = 0, prev_p = 0;
  bit   act = 0;
  bit   lvl0 = 0;
  int   f = 0;
  int   sfall = 0;
  int   pe[$];
  pub_t pq[$];
  int   to_q[$];

  function automatic void do_publish(input int n);
    pub_t r;
    int   i;
    bit   ok;
    r.at = n + 4;  r.per = 32'(n - f);  r.sw = 32'(sfall);
    r.p1 = 0;  r.p2s = 0;  r.p2e = 0;  r.xc = 8'd0;  r.xw = 0;  r.inc = 1'b1;
    i = 0;  ok = 1'b1;
    if (lvl0) begin
      if (pe.size() > 0) begin r.p1 = 32'(pe[0]); i = 1; end
      else ok = 1'b0;
    end
    if (ok && i < pe.size()) r.p2s = 32'(pe[i]);
    if (ok && i + 1 < pe.size()) begin r.p2e = 32'(pe[i+1]); r.inc = 1'b0; end
    if (ok) begin
      for (int k = i + 2; k < pe.size(); k += 2) begin
        if (r.xc != 8'hFF) r.xc = r.xc + 8'd1;
        if (k + 1 < pe.size()) r.xw = 32'(pe[k+1] - pe[k]);
      end
    end
    pq.push_back(r);
  endfunction

  always @(posedge clk_pll) begin : model
    bit s, p;
    int n;
    if (meas_valid)  valid_cnt++;
    if (err_timeout) last_to_edge = edge_cnt;
    edge_cnt++;
    n = edge_cnt;
    if (reset) begin
      prev_v = 1'b0;  act = 1'b0;  rst_edge = n;
      pq.delete();  to_q.delete();  pe.delete();
    end else begin
      s = sync_on;  p = pulse_on;
      if (prev_v && s && !prev_s) begin
        if (act) do_publish(n);
        act = 1'b1;  f = n;  lvl0 = p;  sfall = 0;  pe.delete();
      end else if (act) begin
        if (p != prev_p) pe.push_back(n - f);
        if (!s && prev_s) sfall = n - f;
        if (n - f == T_OUT) begin
          to_q.push_back(n + 3);
          act = 1'b0;
        end
      end
      prev_v = 1'b1;  prev_s = s;  prev_p = p;
    end
  end

  logic [31:0] e_per = 0, e_sw = 0, e_p1 = 0, e_p2s = 0, e_p2e = 0, e_xw = 0;
  logic [7:0]  e_xc = 0;
  logic        e_inc = 0;

  always @(negedge clk_pll) begin : compare
    logic ev, et;
    if (rst_edge == edge_cnt) begin
      e_per = 0; e_sw = 0; e_p1 = 0; e_p2s = 0; e_p2e = 0; e_xw = 0; e_xc = 0; e_inc = 0;
    end
    ev = 1'b0;
    if (pq.size() > 0 && pq[0].at == edge_cnt) begin
      e_per = pq[0].per; e_sw = pq[0].sw; e_p1 = pq[0].p1; e_p2s = pq[0].p2s;
      e_p2e = pq[0].p2e; e_xw = pq[0].xw; e_xc = pq[0].xc; e_inc = pq[0].inc;
      ev = 1'b1;
      void'(pq.pop_front());
    end
    et = 1'b0;
    if (to_q.size() > 0 && to_q[0] == edge_cnt) begin
      et = 1'b1;
      void'(to_q.pop_front());
    end
    chk("meas_valid",       32'(meas_valid),       32'(ev));
    chk("err_timeout",      32'(err_timeout),      32'(et));
    chk("err_incomplete",   32'(err_incomplete),   32'(e_inc));
    chk("meas_period",      meas_period,           e_per);
    chk("meas_syncw",       meas_syncw,            e_sw);
    chk("meas_p1width",     meas_p1width,          e_p1);
    chk("meas_p2start",     meas_p2start,          e_p2s);
    chk("meas_p2end",       meas_p2end,            e_p2e);
    chk("meas_extra_cnt",   32'(meas_extra_cnt),   32'(e_xc));
    chk("meas_extra_width", meas_extra_width,      e_xw);
  end

  function automatic bit xpulse(input int j, input int xs, input int xw, input int xgap, input int xn);
    int r;
    if (xn == 0 || j < xs) return 1'b0;
    r = j - xs;
    return ((r / (xw + xgap)) < xn) && ((r % (xw + xgap)) < xw);
  endfunction

  task automatic drive_frame(input int period, input int syncw, input int p1w,
                             input int p2s, input int p2e, input int xs, input int xw,
                             input int xgap, input int xn, input int rst_at);
    for (int j = 0; j < period; j++) begin
      @(negedge clk_pll);
      if (j == 0) rise_edge = edge_cnt + 1;
      if (rst_at >= 0 && j == rst_at + 1) begin
        chk("lit_rst_period", meas_period, 32'd0);
        chk("lit_rst_p2start", meas_p2start, 32'd0);
      end
      if (rst_at >= 0) reset = (j >= rst_at && j < rst_at + 2);
      if (rst_at >= 0 && j == rst_at + 2) valid_cnt = 0;
      sync_on  = (j < syncw);
      pulse_on = (j < p1w) || (j >= p2s && j < p2e) || xpulse(j, xs, xw, xgap, xn);
    end
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) begin
      @(negedge clk_pll);
      sync_on  = 1'b0;
      pulse_on = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1;  sync_on = 1'b0;  pulse_on = 1'b0;
    repeat (3) @(negedge clk_pll);
    chk("lit_reset_valid",  32'(meas_valid), 32'd0);
    chk("lit_reset_period", meas_period,     32'd0);
    chk("lit_reset_to",     32'(err_timeout), 32'd0);
    reset = 1'b0;
    idle(10);

    // nominal frames
    repeat (3) drive_frame(1000, 250, 50, 200, 250, 0, 1, 1, 0, -1);
    chk("lit_nom_period", meas_period,  32'd1000);
    chk("lit_nom_syncw",  meas_syncw,   32'd250);
    chk("lit_nom_p1",     meas_p1width, 32'd50);
    chk("lit_nom_p2s",    meas_p2start, 32'd200);
    chk("lit_nom_p2e",    meas_p2end,   32'd250);
    chk("lit_nom_xc",     32'(meas_extra_cnt), 32'd0);
    chk("lit_nom_inc",    32'(err_incomplete), 32'd0);

    // pump off
    repeat (2) drive_frame(1000, 250, 0, 200, 250, 0, 1, 1, 0, -1);
    chk("lit_pump_p1",  meas_p1width, 32'd0);
    chk("lit_pump_p2s", meas_p2start, 32'd200);
    chk("lit_pump_p2e", meas_p2end,   32'd250);

    // one extra pulse
    repeat (2) drive_frame(1000, 250, 0, 200, 250, 600, 19, 1, 1, -1);
    chk("lit_extra_cnt",   32'(meas_extra_cnt), 32'd1);
    chk("lit_extra_width", meas_extra_width,    32'd19);

    // extra count saturation
    repeat (2) drive_frame(2000, 250, 0, 10, 20, 30, 3, 3, 300, -1);
    chk("lit_sat_cnt",   32'(meas_extra_cnt), 32'd255);
    chk("lit_sat_width", meas_extra_width,    32'd3);
    chk("lit_sat_per",   meas_period,         32'd2000);

    // truncated frames
    repeat (2) drive_frame(1000, 250, 0, 0, 0, 0, 1, 1, 0, -1);
    chk("lit_trunc_inc", 32'(err_incomplete), 32'd1);
    chk("lit_trunc_p2s", meas_p2start, 32'd0);
    chk("lit_trunc_p2e", meas_p2end,   32'd0);
    chk("lit_trunc_per", meas_period,  32'd1000);

    // timeout: one rise, then silence
    valid_cnt = 0;
    drive_frame(5100, 250, 50, 200, 250, 0, 1, 1, 0, -1);
    chk("lit_to_latency", 32'(last_to_edge - rise_edge), 32'd5003);
    chk("lit_to_valids",  32'(valid_cnt), 32'd1);
    valid_cnt = 0;
    repeat (2) drive_frame(1000, 250, 50, 200, 250, 0, 1, 1, 0, -1);
    idle(10);
    chk("lit_after_to_valids", 32'(valid_cnt), 32'd1);
    chk("lit_after_to_period", meas_period,    32'd1000);

    // reset mid-frame
    drive_frame(1000, 250, 50, 200, 250, 0, 1, 1, 0, 120);
    drive_frame(1000, 250, 50, 200, 250, 0, 1, 1, 0, -1);
    chk("lit_rst_one_rise", 32'(valid_cnt), 32'd0);
    drive_frame(10, 250, 50, 200, 250, 0, 1, 1, 0, -1);
    chk("lit_rst_valids", 32'(valid_cnt), 32'd1);
    chk("lit_rst_after_period", meas_period, 32'd1000);
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
